// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the pipelined ALU.
package alu_pkg;
  localparam logic [1:0] OP_SUB   = 2'b00;
  localparam logic [1:0] OP_NAND  = 2'b01;
  localparam logic [1:0] OP_LEAD1 = 2'b10;
  localparam logic [1:0] OP_OH2U2 = 2'b11;

  localparam int FLG_ERR = 0;
  localparam int FLG_NEG = 1;
  localparam int FLG_POS = 2;
  localparam int FLG_OVF = 3;
endpackage

// File: rtl/alu_core.sv
// Combinational datapath: SUB / NAND / leading-ones / one-hot-to-index decode,
// plus the err/neg/pos/overflow flag vector on the final result.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       oper,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);
  logic [WIDTH-1:0] diff, lead, idx;
  logic             sub_ovf, ovf, err, run, hit, multi;

  always_comb begin
    diff    = a - b;
    sub_ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);

    // One MSB-first scan feeds both the leading-ones count and the one-hot decode.
    lead  = '0;
    idx   = '0;
    run   = 1'b1;
    hit   = 1'b0;
    multi = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      run = run & a[i];
      if (run) lead = lead + WIDTH'(1);
      if (a[i]) begin
        multi = multi | hit;
        hit   = 1'b1;
        idx   = WIDTH'(i);
      end
    end

    result = '0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (oper)
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf;
        if (SAT && sub_ovf)
          result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      OP_NAND:  result = ~(a & b);
      OP_LEAD1: result = lead;
      default: begin
        result = (hit & ~multi) ? idx : '0;
        err    = ~hit | multi;
      end
    endcase

    flag          = '0;
    flag[FLG_ERR] = err;
    flag[FLG_NEG] = result[WIDTH-1] & (|result);
    flag[FLG_POS] = ~result[WIDTH-1] & (|result);
    flag[FLG_OVF] = ovf;
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, result register,
// and a saturating count of delivered error beats.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SAT      = 1'b0,
  parameter int ERRCNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTH-1:0]    i_arg0,
  input  logic [WIDTH-1:0]    i_arg1,
  input  logic [1:0]          i_oper,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTH-1:0]    o_result,
  output logic [3:0]          o_flag,
  output logic [ERRCNT_W-1:0] o_err_cnt,
  input  logic                i_clr_err
);
  logic             s1_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, core_result;
  logic [1:0]       s1_oper;
  logic [3:0]       core_flag;

  assign s2_adv  = ~o_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign o_ready = s1_adv;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_oper  <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_a    <= i_arg0;
        s1_b    <= i_arg1;
        s1_oper <= i_oper;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .oper   (s1_oper),
    .result (core_result),
    .flag   (core_flag)
  );

  // Result/flags only load with a real beat, so they hold while stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flag   <= '0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= core_result;
        o_flag   <= core_flag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      o_err_cnt <= '0;
    else if (i_clr_err)
      o_err_cnt <= '0;
    else if (o_valid & i_ready & o_flag[FLG_ERR] & ~&o_err_cnt)
      o_err_cnt <= o_err_cnt + ERRCNT_W'(1);
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: two instances (wrapping/2-bit counter, saturating/8-bit
// counter) share stimulus and are checked against a capacity-2 FIFO model.
module tb_alu_pipe;
  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_valid = 1'b0, i_ready = 1'b0, i_clr_err = 1'b0;
  logic [3:0] i_arg0 = '0, i_arg1 = '0;
  logic [1:0] i_oper = '0;
  logic       rdy_a, rdy_b, vld_a, vld_b;
  logic [3:0] res_a, res_b, flg_a, flg_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  always #5 i_clk = ~i_clk;

  alu_pipe #(.WIDTH(4), .SAT(1'b0), .ERRCNT_W(2)) dut_a (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(rdy_a),
    .i_arg0(i_arg0), .i_arg1(i_arg1), .i_oper(i_oper), .o_valid(vld_a),
    .i_ready(i_ready), .o_result(res_a), .o_flag(flg_a), .o_err_cnt(cnt_a),
    .i_clr_err(i_clr_err));

  alu_pipe #(.WIDTH(4), .SAT(1'b1), .ERRCNT_W(8)) dut_b (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(rdy_b),
    .i_arg0(i_arg0), .i_arg1(i_arg1), .i_oper(i_oper), .o_valid(vld_b),
    .i_ready(i_ready), .o_result(res_b), .o_flag(flg_b), .o_err_cnt(cnt_b),
    .i_clr_err(i_clr_err));

  typedef struct {
    logic [3:0] ra, fa, rb, fb;
    logic       err;
    int         edge_acc;
  } beat_t;

  beat_t q[$];
  int n_checks = 0, n_fail = 0;
  int edge_n = 0, n_deliv = 0;
  int m_cnt_a = 0, m_cnt_b = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic and bit counting, 4-bit operands.
  function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                                input bit sat, output logic [3:0] r, output logic [3:0] f);
    int sa, sb, d, n;
    bit ovf, err;
    ovf = 0; err = 0; r = '0;
    case (op)
      2'd0: begin
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        d  = sa - sb;
        ovf = (d > 7) || (d < -8);
        if (ovf && sat) d = (d > 7) ? 7 : -8;
        r = d[3:0];
      end
      2'd1: r = ~(a & b);
      2'd2: begin
        n = 0;
        for (int i = 3; i >= 0; i--) begin
          if (!a[i]) break;
          n++;
        end
        r = n[3:0];
      end
      default: begin
        if ($countones(a) == 1) begin
          n = $clog2(a);
          r = n[3:0];
        end else err = 1;
      end
    endcase
    f = {ovf, (r != 0) && !r[3], (r != 0) && r[3], err};
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bit exp_rdy, exp_vld, del;
    beat_t nb;
    @(negedge i_clk);
    exp_rdy = (q.size() < 2) || i_ready;
    exp_vld = (q.size() > 0) && (q[0].edge_acc < edge_n);
    chk("ready_a", rdy_a, exp_rdy);
    chk("ready_b", rdy_b, exp_rdy);
    chk("valid_a", vld_a, exp_vld);
    chk("valid_b", vld_b, exp_vld);
    if (exp_vld) begin
      chk("result_a", res_a, q[0].ra);
      chk("flag_a",   flg_a, q[0].fa);
      chk("result_b", res_b, q[0].rb);
      chk("flag_b",   flg_b, q[0].fb);
    end
    chk("errcnt_a", cnt_a, m_cnt_a);
    chk("errcnt_b", cnt_b, m_cnt_b);
    last_acc = i_valid && exp_rdy;
    del = exp_vld && i_ready;
    if (last_acc) begin
      model(i_arg0, i_arg1, i_oper, 1'b0, nb.ra, nb.fa);
      model(i_arg0, i_arg1, i_oper, 1'b1, nb.rb, nb.fb);
      nb.err = nb.fa[0];
    end
    @(posedge i_clk);
    edge_n++;
    if (i_clr_err) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (del && q[0].err) begin
      if (m_cnt_a < 3) m_cnt_a++;
      if (m_cnt_b < 255) m_cnt_b++;
    end
    if (del) begin
      void'(q.pop_front());
      n_deliv++;
    end
    if (last_acc) begin
      nb.edge_acc = edge_n;
      q.push_back(nb);
    end
    #1;
  endtask

  // Directed beat with hand-derived expectations replacing the model's.
  task automatic send_dir(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] ra, input logic [3:0] fa,
                          input logic [3:0] rb, input logic [3:0] fb);
    bit got;
    got = 0;
    i_valid = 1; i_arg0 = a; i_arg1 = b; i_oper = op;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = last_acc;
    end
    if (!got) chk("accept_timeout", 0, 1);
    else begin
      q[q.size()-1].ra = ra; q[q.size()-1].fa = fa;
      q[q.size()-1].rb = rb; q[q.size()-1].fb = fb;
      q[q.size()-1].err = fa[0];
    end
    i_valid = 0;
  endtask

  task automatic idle(input int n);
    i_valid = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld_a"}, vld_a, 0);
    chk({tag, "_vld_b"}, vld_b, 0);
    chk({tag, "_res_a"}, res_a, 0);
    chk({tag, "_res_b"}, res_b, 0);
    chk({tag, "_flg_a"}, flg_a, 0);
    chk({tag, "_flg_b"}, flg_b, 0);
    chk({tag, "_cnt_a"}, cnt_a, 0);
    chk({tag, "_cnt_b"}, cnt_b, 0);
  endtask

  initial begin
    int sent, base, waited;
    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_zero("reset");
    chk("reset_ready", rdy_a, 1);
    i_rstn = 1;
    @(posedge i_clk); #1;
    i_ready = 1;

    // Directed vectors (A-instance wraps, B-instance saturates)
    send_dir(4'b0011, 4'b0101, 2'b00, 4'b1110, 4'b0010, 4'b1110, 4'b0010);
    send_dir(4'b0111, 4'b1111, 2'b00, 4'b1000, 4'b1010, 4'b0111, 4'b1100);
    send_dir(4'b0100, 4'b0000, 2'b11, 4'b0010, 4'b0100, 4'b0010, 4'b0100);
    send_dir(4'b0110, 4'b1010, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    send_dir(4'b1101, 4'b0000, 2'b10, 4'b0010, 4'b0100, 4'b0010, 4'b0100);
    send_dir(4'b1111, 4'b1111, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    send_dir(4'b1000, 4'b0001, 2'b00, 4'b0111, 4'b1100, 4'b1000, 4'b1010);
    idle(3);
    chk("oh2u2_err_once", cnt_a, 1);

    // Backpressure: 5 beats, consumer stalled cycles 2..5, operands churn while blocked
    base = n_deliv; sent = 0;
    for (int c = 0; c < 16; c++) begin
      i_valid = (sent < 5);
      i_arg0 = 4'($urandom_range(0, 15));
      i_arg1 = 4'($urandom_range(0, 15));
      i_oper = 2'($urandom_range(0, 3));
      i_ready = !(c >= 2 && c <= 5);
      if (c == 5) chk("bp_ready_low", rdy_a, 0);
      tick();
      if (last_acc) sent++;
    end
    chk("bp_delivered", n_deliv - base, 5);
    i_valid = 0; i_ready = 1;

    // Random traffic, biased toward one-hot operands
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_clr_err = ($urandom_range(0, 24) == 0);
      i_oper = 2'($urandom_range(0, 3));
      i_arg0 = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      i_arg1 = 4'($urandom_range(0, 15));
      tick();
    end
    i_valid = 0; i_ready = 1; i_clr_err = 0;
    idle(3);

    // Error counter saturation on the 2-bit instance, then clear beating an increment
    i_clr_err = 1; tick(); i_clr_err = 0;
    for (int k = 0; k < 5; k++) send_dir(4'b0000, 4'b0000, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    idle(3);
    chk("errcnt_saturated", cnt_a, 3);
    chk("errcnt_b_five", cnt_b, 5);
    send_dir(4'b0011, 4'b0000, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    waited = 0;
    while (!(q.size() > 0 && q[0].edge_acc < edge_n) && waited < 10) begin
      tick();
      waited++;
    end
    if (waited >= 10) chk("clr_wait_timeout", 0, 1);
    i_clr_err = 1; tick(); i_clr_err = 0;
    tick();
    chk("clr_wins_a", cnt_a, 0);
    chk("clr_wins_b", cnt_b, 0);

    // Mid-stream reset with a nonzero counter and both stages full
    send_dir(4'b0101, 4'b0000, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    idle(3);
    i_ready = 0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1;
      i_arg0 = 4'($urandom_range(1, 15)); i_arg1 = 4'($urandom_range(0, 15)); i_oper = 2'b01;
      tick();
    end
    i_valid = 0;
    @(negedge i_clk); #2;
    i_rstn = 0;
    #1;
    chk_zero("async_rst");
    q.delete();
    m_cnt_a = 0; m_cnt_b = 0;
    @(negedge i_clk);
    i_rstn = 1;
    @(posedge i_clk); #1;
    i_ready = 1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
